// File: rtl/tl_ram_slave_if.sv
// TileLink-UL single-beat channel bundle: A (request) and D (response), 4-bit source IDs.
interface tilelink;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic        d_corrupt;
    logic [63:0] d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
    );
    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data
    );
endinterface

// File: rtl/tl_ram_slave.sv
// TileLink-UL responder over a 64-bit word RAM, one request in flight, LATENCY wait cycles.
// Define TL_RAM_SLAVE_ERR_EN to deny out-of-range, unsupported or misaligned requests.
module tl_ram_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    tilelink.slave     bus,
    output logic [1:0] dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a transfer happens on a channel at a rising clk edge where valid && ready;
    // the D payload is held stable from d_valid rising until its transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        a_ready_q, d_valid_q;
    logic [3:0]  cnt;
    logic [2:0]  opcode_q, size_q;
    logic [3:0]  source_q;
    logic [63:0] addr_q, data_q;
    logic [7:0]  mask_q;
    logic [2:0]  d_opcode_q, d_size_q;
    logic [3:0]  d_source_q;
    logic        d_denied_q;
    logic [63:0] d_data_q;
    logic [63:0] mem [DEPTH];

    logic              accept, enter_resp, mem_we, cur_get, cur_denied;
    logic [2:0]        cur_opcode, cur_size;
    logic [3:0]        cur_source;
    logic [63:0]       cur_addr, cur_data, offset;
    logic [7:0]        cur_mask;
    logic [IDX_W-1:0]  idx;

    assign accept = (state == IDLE) && a_ready_q && bus.a_valid;

    // With LATENCY=0 RESP is entered on the acceptance edge, so the live A fields are used.
    assign cur_opcode = (state == IDLE) ? bus.a_opcode  : opcode_q;
    assign cur_size   = (state == IDLE) ? bus.a_size    : size_q;
    assign cur_source = (state == IDLE) ? bus.a_source  : source_q;
    assign cur_addr   = (state == IDLE) ? bus.a_address : addr_q;
    assign cur_mask   = (state == IDLE) ? bus.a_mask    : mask_q;
    assign cur_data   = (state == IDLE) ? bus.a_data    : data_q;

    assign offset = cur_addr - BASE_ADDR;
    assign idx    = offset[IDX_W+2:3];

`ifdef TL_RAM_SLAVE_ERR_EN
    logic [2:0] align_m;
    assign align_m    = 3'((4'd1 << cur_size[1:0]) - 4'd1);
    assign cur_get    = (cur_opcode == 3'd4);
    assign cur_denied = (offset[63:IDX_W+3] != '0)
                     || !(cur_opcode inside {3'd0, 3'd1, 3'd4})
                     || (cur_size > 3'd3)
                     || ((offset[2:0] & align_m) != 3'd0);
`else
    assign cur_get    = (cur_opcode[2:1] != 2'b00);
    assign cur_denied = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{offset, bus.a_param};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (bus.d_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);
    assign mem_we     = enter_resp && !cur_get && !cur_denied;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ready_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            cnt        <= '0;
            opcode_q   <= '0;
            size_q     <= '0;
            source_q   <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
        end else begin
            a_ready_q <= (state_nxt == IDLE);
            d_valid_q <= (state_nxt == RESP);
            if (accept) begin
                opcode_q <= bus.a_opcode;
                size_q   <= bus.a_size;
                source_q <= bus.a_source;
                addr_q   <= bus.a_address;
                mask_q   <= bus.a_mask;
                data_q   <= bus.a_data;
                cnt      <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                d_opcode_q <= cur_get ? 3'd1 : 3'd0;
                d_size_q   <= cur_size;
                d_source_q <= cur_source;
                d_denied_q <= cur_denied;
                d_data_q   <= (cur_get && !cur_denied) ? mem[idx] : '0;
            end
        end
    end

    // RAM has no reset; its contents persist across rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (cur_mask[b]) mem[idx][8*b +: 8] <= cur_data[8*b +: 8];
            end
        end
    end

    assign bus.a_ready   = a_ready_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_opcode  = d_opcode_q;
    assign bus.d_param   = 2'd0;
    assign bus.d_size    = d_size_q;
    assign bus.d_source  = d_source_q;
    assign bus.d_denied  = d_denied_q;
    assign bus.d_corrupt = 1'b0;
    assign bus.d_data    = d_data_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_tl_ram_slave.sv
// Directed bench for tl_ram_slave: LATENCY=1 instance for protocol/data, LATENCY=0 for back-to-back.
module tb_tl_ram_slave;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  opc;
        logic        den;
        logic [3:0]  src;
        logic [2:0]  size;
        int          lat;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg1, dbg0;
    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    tilelink tl1 ();
    tilelink tl0 ();

    tl_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(tl1), .dbg_state(dbg1)
    );
    tl_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(tl0), .dbg_state(dbg0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ctl1();
        return {tl1.d_valid, tl1.d_opcode, tl1.d_param, tl1.d_size, tl1.d_source,
                tl1.d_denied, tl1.d_corrupt};
    endfunction

    // One request on the LATENCY=1 instance; d_ready held low for `stall` response cycles.
    task automatic req1(input logic [2:0] op, input logic [63:0] addr, input logic [2:0] size,
                        input logic [3:0] src, input logic [7:0] mask, input logic [63:0] data,
                        input int stall, output resp_t r);
        int guard;
        logic [14:0] hold_ctl;
        r = '{data: '0, opc: '0, den: 1'b0, src: '0, size: '0, lat: 0};
        tl1.d_ready = (stall == 0);
        @(negedge clk);
        tl1.a_valid = 1'b1; tl1.a_opcode = op; tl1.a_param = 3'd0; tl1.a_size = size;
        tl1.a_source = src; tl1.a_address = addr; tl1.a_mask = mask; tl1.a_data = data;
        guard = 0;
        while (!tl1.a_ready && guard < 20) begin @(negedge clk); guard++; end
        check("accept_timeout", 64'(guard >= 20), 64'(0));
        @(negedge clk);
        tl1.a_valid = 1'b0;
        check("a_ready_drop", 64'(tl1.a_ready), 64'(0));
        r.lat = 1;
        while (!tl1.d_valid && r.lat < 20) begin @(negedge clk); r.lat++; end
        check("d_valid_timeout", 64'(r.lat >= 20), 64'(0));
        r.data = tl1.d_data; r.opc = tl1.d_opcode; r.den = tl1.d_denied;
        r.src = tl1.d_source; r.size = tl1.d_size;
        hold_ctl = ctl1();
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            check("stall_ctl", 64'(ctl1()), 64'(hold_ctl));
            check("stall_data", tl1.d_data, r.data);
            check("stall_a_ready", 64'(tl1.a_ready), 64'(0));
        end
        tl1.d_ready = 1'b1;
        @(negedge clk);
        check("a_ready_back", 64'(tl1.a_ready), 64'(1));
        check("d_valid_drop", 64'(tl1.d_valid), 64'(0));
    endtask

    // Full-word write on the LATENCY=0 instance; response must appear one cycle after acceptance.
    task automatic put0(input logic [63:0] addr, input logic [63:0] data);
        int guard;
        tl0.d_ready = 1'b1;
        @(negedge clk);
        tl0.a_valid = 1'b1; tl0.a_opcode = 3'd0; tl0.a_size = 3'd3; tl0.a_mask = 8'hFF;
        tl0.a_address = addr; tl0.a_data = data;
        guard = 0;
        while (!tl0.a_ready && guard < 20) begin @(negedge clk); guard++; end
        check("put0_accept_timeout", 64'(guard >= 20), 64'(0));
        @(negedge clk);
        tl0.a_valid = 1'b0;
        check("put0_d_valid", 64'(tl0.d_valid), 64'(1));
        check("put0_opcode", 64'(tl0.d_opcode), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t r;
        int acc_n, rsp_n, last_acc, t;

        tl1.a_valid = 1'b0; tl1.a_opcode = '0; tl1.a_param = '0; tl1.a_size = '0;
        tl1.a_source = '0; tl1.a_address = '0; tl1.a_mask = '0; tl1.a_data = '0;
        tl1.d_ready = 1'b1;
        tl0.a_valid = 1'b0; tl0.a_opcode = '0; tl0.a_param = '0; tl0.a_size = '0;
        tl0.a_source = '0; tl0.a_address = '0; tl0.a_mask = '0; tl0.a_data = '0;
        tl0.d_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_a_ready", 64'(tl1.a_ready), 64'(0));
        check("rst_d_valid", 64'(tl1.d_valid), 64'(0));
        check("rst_d_denied", 64'(tl1.d_denied), 64'(0));
        check("rst_d_opcode", 64'(tl1.d_opcode), 64'(0));
        check("rst_d_size", 64'(tl1.d_size), 64'(0));
        check("rst_d_source", 64'(tl1.d_source), 64'(0));
        check("rst_d_data", tl1.d_data, 64'(0));
        check("rst_d_param", 64'(tl1.d_param), 64'(0));
        check("rst_d_corrupt", 64'(tl1.d_corrupt), 64'(0));
        check("rst_state", 64'(dbg1), 64'(0));
        check("rst_a_ready0", 64'(tl0.a_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        check("a_ready_before_edge", 64'(tl1.a_ready), 64'(0));
        @(negedge clk);
        check("a_ready_after_edge", 64'(tl1.a_ready), 64'(1));

        // Full write then read back
        req1(3'd0, BASE + 64'h10, 3'd3, 4'd1, 8'hFF, 64'h1122_3344_5566_7788, 0, r);
        check("put_opcode", 64'(r.opc), 64'(0));
        check("put_data", r.data, 64'(0));
        check("put_denied", 64'(r.den), 64'(0));
        check("put_latency", 64'(r.lat), 64'(2));
        req1(3'd4, BASE + 64'h10, 3'd3, 4'd1, 8'hFF, 64'h0, 0, r);
        check("get_opcode", 64'(r.opc), 64'(1));
        check("get_data", r.data, 64'h1122_3344_5566_7788);
        check("get_latency", 64'(r.lat), 64'(2));

        // Partial write of the low four bytes
        req1(3'd1, BASE + 64'h10, 3'd3, 4'd2, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 0, r);
        check("pp_opcode", 64'(r.opc), 64'(0));
        req1(3'd4, BASE + 64'h10, 3'd3, 4'd2, 8'hFF, 64'h0, 0, r);
        check("pp_data", r.data, 64'h1122_3344_CCCC_DDDD);

        // Stalled response with echoed source/size
        req1(3'd4, BASE + 64'h10, 3'd2, 4'd5, 8'hFF, 64'h0, 7, r);
        check("stall_source", 64'(r.src), 64'(5));
        check("stall_size", 64'(r.size), 64'(2));
        check("stall_opcode", 64'(r.opc), 64'(1));
        check("stall_rdata", r.data, 64'h1122_3344_CCCC_DDDD);
        check("stall_latency", 64'(r.lat), 64'(2));

        // Back-to-back Gets on the LATENCY=0 instance
        for (int i = 0; i < 4; i++) put0(BASE + 64'(8 * i), 64'hB0B0_0000_0000_0000 + 64'(i));
        acc_n = 0; rsp_n = 0; last_acc = 0; t = 0;
        tl0.a_opcode = 3'd4; tl0.d_ready = 1'b1;
        while (rsp_n < 4 && t < 40) begin
            @(negedge clk);
            t++;
            tl0.a_valid = (acc_n < 4);
            tl0.a_address = BASE + 64'(8 * acc_n);
            if (tl0.d_valid) begin
                if (exp_q.size() == 0) check("b2b_spurious", 64'(exp_q.size()), 64'(1));
                else check("b2b_data", tl0.d_data, exp_q.pop_front());
                rsp_n++;
            end
            if (tl0.a_valid && tl0.a_ready) begin
                if (acc_n > 0) check("b2b_spacing", 64'(t - last_acc), 64'(2));
                last_acc = t;
                exp_q.push_back(64'hB0B0_0000_0000_0000 + 64'(acc_n));
                acc_n++;
            end
        end
        tl0.a_valid = 1'b0;
        check("b2b_accepts", 64'(acc_n), 64'(4));
        check("b2b_responses", 64'(rsp_n), 64'(4));

        // Reset during WAIT of a write aborts it
        @(negedge clk);
        tl1.a_valid = 1'b1; tl1.a_opcode = 3'd0; tl1.a_size = 3'd3; tl1.a_mask = 8'hFF;
        tl1.a_address = BASE + 64'h10; tl1.a_data = 64'hDEAD_BEEF_DEAD_BEEF;
        check("abort_ready", 64'(tl1.a_ready), 64'(1));
        @(negedge clk);
        tl1.a_valid = 1'b0;
        check("abort_in_wait", 64'(dbg1), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort_d_valid_now", 64'(tl1.d_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", 64'(tl1.d_valid), 64'(0));
        end
        req1(3'd4, BASE + 64'h10, 3'd3, 4'd3, 8'hFF, 64'h0, 0, r);
        check("abort_ram_kept", r.data, 64'h1122_3344_CCCC_DDDD);

`ifdef TL_RAM_SLAVE_ERR_EN
        req1(3'd0, BASE, 3'd3, 4'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, r);
        check("err_w0_denied", 64'(r.den), 64'(0));
        req1(3'd4, 64'h7FFF_FFF8, 3'd3, 4'd0, 8'hFF, 64'h0, 0, r);
        check("err_low_denied", 64'(r.den), 64'(1));
        check("err_low_data", r.data, 64'(0));
        check("err_low_opcode", 64'(r.opc), 64'(1));
        check("err_low_latency", 64'(r.lat), 64'(2));
        req1(3'd0, BASE + 64'h4, 3'd3, 4'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, r);
        check("err_align_denied", 64'(r.den), 64'(1));
        check("err_align_opcode", 64'(r.opc), 64'(0));
        req1(3'd4, BASE, 3'd3, 4'd0, 8'hFF, 64'h0, 0, r);
        check("err_w0_kept", r.data, 64'h0123_4567_89AB_CDEF);
        check("err_w0_get_denied", 64'(r.den), 64'(0));
`else
        req1(3'd4, BASE + 64'(DEPTH * 8) + 64'h10, 3'd3, 4'd0, 8'hFF, 64'h0, 0, r);
        check("wrap_data", r.data, 64'h1122_3344_CCCC_DDDD);
        check("wrap_denied", 64'(r.den), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tl_ram_slave.md
# tl_ram_slave

TileLink-UL responder fronting a single-ported 64-bit word RAM. It is the slave end of the `tilelink` interface that the CPU drives from its fetch and memory-access ports, directly or behind the bus arbiter. It serves single-beat Get, PutFullData and PutPartialData requests with one request in flight and a parameterised response latency. It is the default boot/data memory for simulation and FPGA builds.

## Interface
- `BASE_ADDR`, 64'h8000_0000, byte address of word 0; must be aligned to DEPTH*8.
- `DEPTH`, 1024, number of 64-bit words; power of two, at least 2.
- `LATENCY`, 1, extra wait cycles between request acceptance and response; 0..15.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `bus` tilelink.slave: A channel carries a_valid, a_ready, a_opcode[2:0], a_param[2:0], a_size[2:0], a_source, a_address[63:0], a_mask[7:0], a_data[63:0]. D channel carries d_valid, d_ready, d_opcode[2:0], d_param[1:0], d_size[2:0], d_source, d_denied, d_corrupt, d_data[63:0].

## Operation
- A-channel opcodes: PutFullData=0, PutPartialData=1, Get=4. D-channel opcodes: AccessAck=0, AccessAckData=1.
- State machine states:
  - IDLE: a_ready=1.
  - WAIT: counter loaded with LATENCY.
  - RESP: d_valid=1.
- IDLE transitions:
  - On a_valid&&a_ready, latch opcode, size, source, address, mask and data.
  - Go to WAIT if LATENCY>0, else go to RESP.
- WAIT: counter decrements each cycle. At counter==1 go to RESP.
- RESP: hold all d_* stable until d_ready. On d_valid&&d_ready return to IDLE.
- Word index is (a_address-BASE_ADDR)>>3, truncated to log2(DEPTH) bits.
- Memory action, performed on the cycle the FSM enters RESP:
  - Get: d_data is the full 64-bit word at the index, with all lanes driven. d_opcode=AccessAckData.
  - PutFullData and PutPartialData: write the bytes selected by the latched a_mask, other bytes unchanged. d_opcode=AccessAck, d_data=0.
- d_size and d_source echo the latched request. d_param=0 and d_corrupt=0 always.
- The RAM itself is not reset. Its contents are X until written.

## Timing
- Reset values:
  - a_ready=0, d_valid=0, d_denied=0, d_opcode=0, d_size=0, d_source=0, d_data=0.
  - FSM in IDLE. a_ready rises on the first clk edge after rst_n deasserts.
- Latency: the acceptance edge is cycle 0. d_valid is high from cycle LATENCY+1 onward.
- Throughput: at most one request per LATENCY+2 cycles.
  - a_ready drops in the cycle after acceptance.
  - a_ready returns high in the cycle after the D handshake.
- a_ready is 0 throughout WAIT and RESP. Acceptance can therefore never coincide with a D handshake.
- d_ready held low stalls RESP indefinitely. The write is still performed exactly once, on entering RESP.
- rst_n asserting mid-transaction aborts it immediately. The response is lost and outputs go to their reset values. A write not yet at RESP is not performed.
- Address arithmetic is 64-bit unsigned. Wrap-around below BASE_ADDR falls out of range (see Configuration).

## Configuration
- Macro: `TL_RAM_SLAVE_ERR_EN`.
- Defined: a request is denied if any of the following holds:
  - its address is outside [BASE_ADDR, BASE_ADDR+DEPTH*8);
  - its opcode is not in {0,1,4};
  - a_size>3;
  - its address is not aligned to 1<<a_size.
- A denied request:
  - gets d_denied=1 with the normal opcode mapping (unsupported opcode maps to AccessAck);
  - returns d_data=0;
  - does not modify the RAM;
  - keeps the same latency as a normal request.
- Not defined:
  - No checks are made; d_denied is tied to 0.
  - The index always wraps modulo DEPTH.
  - Any opcode other than 0/1 is treated as Get.

## Test plan
- Reset, then PutFullData to 0x8000_0010 with data 64'h1122_3344_5566_7788 and mask 8'hFF; then Get from 0x8000_0010. Required:
  - AccessAck, then AccessAckData with d_data=64'h1122_3344_5566_7788;
  - each response's d_valid is high exactly LATENCY+1 cycles after its acceptance.
- PutPartialData to 0x8000_0010 with mask 8'h0F and data 64'hAAAA_BBBB_CCCC_DDDD, then Get. Required: d_data=64'h1122_3344_CCCC_DDDD.
- Get with a_source=5, a_size=2, and d_ready held low for 7 cycles. Required:
  - d_valid and all d_* stay constant for those 7 cycles;
  - d_source=5, d_size=2;
  - a_ready stays 0 until the cycle after the handshake.
- Back-to-back a_valid held high for 4 Gets with LATENCY=0 and d_ready=1. Required: exactly one acceptance every 2 cycles, and 4 responses in order.
- Assert rst_n low during WAIT of a PutFullData, then release and Get the same address. Required:
  - no D response for the aborted request;
  - the RAM word is unchanged by the aborted write.
- With `TL_RAM_SLAVE_ERR_EN`:
  - a Get at 0x7FFF_FFF8 returns d_denied=1, d_data=0;
  - a PutFullData at 0x8000_0004 with a_size=3 returns d_denied=1 and leaves word 0 unchanged.
